// File: rtl/led_chaser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_chaser_pkg
// Description : Shared mode and direction encodings for the LED chaser.
// Revision    : 1.0 - initial release
// ============================================================================
package led_chaser_pkg;

  // Pattern update modes, selected by the 2-bit mode input
  typedef enum logic [1:0] {
    MODE_ROL    = 2'd0,
    MODE_ROR    = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  // Bounce direction: left moves the lit bits toward the MSB
  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

endpackage : led_chaser_pkg
`default_nettype wire

// File: rtl/led_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : led_prescaler
// Description : Programmable divider producing a one-cycle tick every
//               period+1 enabled cycles. Count freezes while enable is low;
//               clear restarts the interval from zero.
// Revision    : 1.0 - initial release
// ============================================================================
module led_prescaler #(
  parameter int DIV_BITS = 27
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                enable,
  input  logic [DIV_BITS-1:0] period,
  input  logic                clear,
  output logic [DIV_BITS-1:0] count,
  output logic                tick
);

  logic [DIV_BITS-1:0] count_d;
  logic [DIV_BITS-1:0] count_q;

  // Terminal count reached while running. If period drops below the current
  // count, the counter simply wraps through zero before matching again.
  assign tick = enable && (count_q == period);

  // Next count: clear beats tick, tick restarts, enable advances, else hold
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tick) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : led_prescaler
`default_nettype wire

// File: rtl/led_chaser.sv
`default_nettype none
// ============================================================================
// Module      : led_chaser
// Description : Parametrised LED pattern generator. A prescaler tick advances
//               a WIDTH-bit pattern by rotate-left, rotate-right, bounce or
//               hold. A synchronous load replaces the pattern and restarts
//               the prescaler interval. WIDTH must be at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
module led_chaser
  import led_chaser_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               DIV_BITS = 27,
  parameter logic [WIDTH-1:0] INIT     = WIDTH'(1)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                enable,
  input  logic [DIV_BITS-1:0] period,
  input  logic [1:0]          mode,
  input  logic                load,
  input  logic [WIDTH-1:0]    load_val,
  output logic [WIDTH-1:0]    gpio,
  output logic [DIV_BITS-1:0] count,
  output logic                step,
  output logic                dir
);

  logic             tick;
  logic [WIDTH-1:0] gpio_d;
  logic [WIDTH-1:0] gpio_q;
  dir_e             dir_d;
  dir_e             dir_q;
  logic             step_d;
  logic             step_q;

  function automatic logic [WIDTH-1:0] rot_left(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], v[WIDTH-1]};
  endfunction

  function automatic logic [WIDTH-1:0] rot_right(input logic [WIDTH-1:0] v);
    return {v[0], v[WIDTH-1:1]};
  endfunction

  // A load restarts the step interval so the new pattern is shown for a
  // full period before it first moves.
  led_prescaler #(
    .DIV_BITS (DIV_BITS)
  ) u_prescaler (
    .clk    (clk),
    .rstn   (rstn),
    .enable (enable),
    .period (period),
    .clear  (load),
    .count  (count),
    .tick   (tick)
  );

  // Next pattern, direction and step strobe; load wins over a coincident tick
  always_comb begin
    gpio_d = gpio_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    if (load) begin
      gpio_d = load_val;
      dir_d  = DIR_LEFT;
    end else if (tick) begin
      step_d = 1'b1;
      case (mode_e'(mode))
        MODE_ROL: gpio_d = rot_left(gpio_q);
        MODE_ROR: gpio_d = rot_right(gpio_q);
        MODE_BOUNCE: begin
          // Turn around on the step that finds the leading bit at the edge,
          // so the edge pattern is shown for a full interval.
          if (dir_q == DIR_LEFT) begin
            if (gpio_q[WIDTH-1]) begin
              dir_d  = DIR_RIGHT;
              gpio_d = rot_right(gpio_q);
            end else begin
              gpio_d = rot_left(gpio_q);
            end
          end else begin
            if (gpio_q[0]) begin
              dir_d  = DIR_LEFT;
              gpio_d = rot_left(gpio_q);
            end else begin
              gpio_d = rot_right(gpio_q);
            end
          end
        end
        default: gpio_d = gpio_q;  // hold: prescaler and step keep running
      endcase
    end
  end

  // Output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gpio_q <= INIT;
      dir_q  <= DIR_LEFT;
      step_q <= 1'b0;
    end else begin
      gpio_q <= gpio_d;
      dir_q  <= dir_d;
      step_q <= step_d;
    end
  end

  assign gpio = gpio_q;
  assign step = step_q;
  assign dir  = dir_q;

endmodule : led_chaser
`default_nettype wire
